ks_sum_stage: RTL and testbench

- Final, downstream stage of the 32-bit Kogge-Stone adder.
- Consumes the per-bit propagate vector and the fully resolved prefix group-generate vector from the last prefix level.
- Forms sum, carry-out, signed overflow and zero flag, and registers them behind a valid/ready skid buffer so the adder can sit in a pipelined datapath.
- Throughput is 1 result/cycle; latency is 1 cycle.

---
 rtl/ks_pkg.sv | 17 +
 rtl/ks_skid_buf.sv | 81 ++++++++
 rtl/ks_sum_stage.sv | 65 ++++++
 tb/tb_ks_sum_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared width and result record for the Kogge-Stone sum stage
//
// Purpose: common definitions for the final stage of the 32-bit Kogge-Stone
// adder. The prefix tree is built only for KS_WIDTH = 32.
package ks_pkg;

    localparam int KS_WIDTH = 32;

    // Registered result record, WIDTH+3 bits, sum in the MSBs.
    typedef struct packed {
        logic [KS_WIDTH-1:0] sum;
        logic                cout;
        logic                ovf;
        logic                zero;
    } ks_result_t;

endpackage

// File: rtl/ks_skid_buf.sv
// rtl/ks_skid_buf.sv - 2-entry valid/ready skid buffer over ks_result_t
//
// Purpose: registers a result record with full throughput while keeping
// in_ready a pure flop output (no combinational ready path).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake, in_ready = ~skid valid
//   in_data              record to store
//   out_valid/out_ready  downstream handshake, out_valid = main valid
//   out_data             main (output) register
module ks_skid_buf
    import ks_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  ks_result_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output ks_result_t out_data
);

    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    ks_result_t main_q, main_d;
    ks_result_t skid_q, skid_d;
    logic       accept;
    logic       xfer;

    // Occupancy is implied by the two valid bits:
    // EMPTY (!main), ONE (main & !skid), FULL (main & skid).
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        accept       = in_valid & ~skid_valid_q;
        xfer         = main_valid_q & out_ready;

        if (skid_valid_q) begin
            // FULL: nothing can be accepted; drain skid into main on transfer.
            if (xfer) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (accept && xfer) begin
                // Simultaneous in/out keeps occupancy at one, no bubble.
                main_d = in_data;
            end else if (accept) begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end else if (xfer) begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/ks_sum_stage.sv
// rtl/ks_sum_stage.sv - Kogge-Stone final sum/flag stage with skid-buffered output
//
// Purpose: forms sum, carry-out, signed overflow and zero flag from the
// half-sum vector and the resolved group-generate vector, then registers them
// behind a 2-entry skid buffer (1-cycle latency, 1 result/cycle).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake (in_ready registered)
//   p0                   a ^ b per bit
//   g_grp                carry out of each bit, carry-in folded in
//   cin                  adder carry-in, used only for sum bit 0
//   out_valid/out_ready  downstream handshake
//   sum, cout, ovf, zero registered result
// Only WIDTH = 32 is supported; the record width follows KS_WIDTH.
module ks_sum_stage
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p0,
    input  logic [WIDTH-1:0] g_grp,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] sum_c;
    ks_result_t       rec_in;
    ks_result_t       rec_out;

    // Carry into bit i is the group generate of bits i-1..0.
    assign sum_c[0]         = p0[0] ^ cin;
    assign sum_c[WIDTH-1:1] = p0[WIDTH-1:1] ^ g_grp[WIDTH-2:0];

    assign rec_in.sum  = sum_c;
    assign rec_in.cout = g_grp[WIDTH-1];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign rec_in.ovf  = g_grp[WIDTH-1] ^ g_grp[WIDTH-2];
    assign rec_in.zero = ~|sum_c;

    ks_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (rec_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (rec_out)
    );

    assign sum  = rec_out.sum;
    assign cout = rec_out.cout;
    assign ovf  = rec_out.ovf;
    assign zero = rec_out.zero;

endmodule

// File: tb/tb_ks_sum_stage.sv
// tb/tb_ks_sum_stage.sv - scoreboard testbench for ks_sum_stage
module tb_ks_sum_stage;
    import ks_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] p0 = '0;
    logic [31:0] g_grp = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout, ovf, zero;

    ks_result_t  obs;
    ks_result_t  exp_q[$];
    ks_result_t  held;
    logic        stalled = 1'b0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          out_cnt = 0;
    int          stall_cnt = 0;
    bit          rnd_done;

    always #5 clk = ~clk;

    ks_sum_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p0        (p0),
        .g_grp     (g_grp),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    assign obs = {sum, cout, ovf, zero};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain 33-bit addition and the sign rule for overflow.
    function automatic ks_result_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [32:0] full;
        ks_result_t  r;
        full   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        r.zero = (full[31:0] == 32'd0);
        return r;
    endfunction

    // Present one operand pair; push the expected record when it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [32:0] full;
        logic [31:0] t;
        bit          done;
        int          n;
        full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        t    = a ^ b ^ full[31:0];   // bit k = carry into bit k
        in_valid = 1'b1;
        p0       = a ^ b;
        g_grp    = {full[32], t[31:1]};
        cin      = ci;
        done = 0;
        n    = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, ci));
                done = 1;
            end else begin
                stall_cnt++;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n >= 60) begin
                total_cnt++;
                $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("no_extra_out", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compares every output transfer and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) chk("hold_stable", 64'(obs), 64'(held));
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out: got %h expected no output", obs);
                end else begin
                    chk("scoreboard", 64'(obs), 64'(exp_q.pop_front()));
                end
            end
            stalled = out_valid && !out_ready;
            held    = obs;
        end
    end

    initial begin : main
        logic [31:0] ra, rb;
        int          base;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", 64'(obs), 64'd0);
        @(posedge clk); #1;

        // Directed vectors, 1-cycle latency.
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        chk("carry_thru_valid", 64'(out_valid), 64'd1);
        chk("carry_thru", 64'(obs), {29'd0, 32'h0, 1'b1, 1'b0, 1'b1});
        @(posedge clk); #1;
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        chk("ovf", 64'(obs), {29'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        send(32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("cin_only", 64'(obs), {29'd0, 32'h1, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        drain();

        // Backpressure: R1 in main, R2 in skid, R3 held off.
        out_ready = 1'b0;
        send($urandom, $urandom, 1'($urandom_range(0, 1)));
        send($urandom, $urandom, 1'($urandom_range(0, 1)));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        fork
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_held_off", 64'(in_ready), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_no_gap", 64'(out_valid), 64'd1);
                end
            end
        join
        drain();

        // Full throughput: 100 back-to-back results.
        stall_cnt = 0;
        base = out_cnt;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ~ra : $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();
        chk("tp_no_stall", 64'(stall_cnt), 64'd0);
        chk("tp_count", 64'(out_cnt - base), 64'd100);

        // Random downstream backpressure.
        base = out_cnt;
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rnd_count", 64'(out_cnt - base), 64'd150);

        // Reset while FULL discards both entries.
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_data", 64'(obs), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = out_cnt;
        send($urandom, $urandom, 1'b1);
        drain();
        chk("post_rst_count", 64'(out_cnt - base), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
